// File: rtl/pic_pc_stack_if.sv
// Decoder/fetch-side bundle for pic_pc_stack: control strobes in, PC and stack status out.
interface pic_pc_stack_if #(
  parameter int PC_W      = 13,
  parameter int JA_W      = 11,
  parameter int STK_DEPTH = 8
);
  localparam int CNT_W = $clog2(STK_DEPTH + 1);

  // No valid/ready handshake: every strobe is a level qualifier sampled at the
  // rising CLK edge, and the outputs are always valid.
  logic              HOLD;
  logic              JMP;
  logic [JA_W-1:0]   JADDR;
  logic              PUSH;
  logic              POP;
  logic              PCL_WE;
  logic [7:0]        PCL_D;
  logic [PC_W-9:0]   PCLATH;
  logic              FLAG_CLR;
  logic [PC_W-1:0]   PC;
  logic [PC_W-1:0]   TOS;
  logic [CNT_W-1:0]  STK_CNT;
  logic              OVF;
  logic              UNF;
  logic              TRAP;

  modport master (
    output HOLD, JMP, JADDR, PUSH, POP, PCL_WE, PCL_D, PCLATH, FLAG_CLR,
    input  PC, TOS, STK_CNT, OVF, UNF, TRAP
  );

  modport slave (
    input  HOLD, JMP, JADDR, PUSH, POP, PCL_WE, PCL_D, PCLATH, FLAG_CLR,
    output PC, TOS, STK_CNT, OVF, UNF, TRAP
  );
endinterface

// File: rtl/pic_pc_stack.sv
// Program counter and hardware return stack with configurable depth and overflow policy.
// Optional macro STK_TRAP_EN: stack faults vector the PC to TRAP_VEC and pulse TRAP.
module pic_pc_stack #(
  parameter int PC_W      = 13,
  parameter int JA_W      = 11,
  parameter int STK_DEPTH = 8,
  parameter int WRAP_MODE = 1,
  parameter int RESET_VEC = 0,
  parameter int TRAP_VEC  = 4
) (
  input logic           CLK,
  input logic           RST,
  pic_pc_stack_if.slave bus
);
  localparam int CNT_W = $clog2(STK_DEPTH + 1);
  localparam int PTR_W = $clog2(STK_DEPTH);
  localparam logic [PC_W-1:0]  RST_PC   = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0]  TRAP_PC  = PC_W'(TRAP_VEC);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STK_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STK_DEPTH);
  localparam bit               WRAP_EN  = (WRAP_MODE != 0);
`ifdef STK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  generate
    if (PC_W < 9 || PC_W > 16 || JA_W >= PC_W || JA_W < 8 || STK_DEPTH < 2) begin : g_bad_cfg
      $error("pic_pc_stack: unsupported parameter combination");
    end
  endgenerate

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             trap_q, trap_d;
  logic [PC_W-1:0]  stk_q [STK_DEPTH];

  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic             push_only, pop_only, full, empty;
  logic             ovf_ev, unf_ev, fault;
  logic             stk_we, pop_vld;
  logic [PC_W-1:0]  pop_pc;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  assign ptr_inc   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec   = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);
  assign push_only = bus.PUSH & ~bus.POP;
  assign pop_only  = bus.POP & ~bus.PUSH;
  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign ovf_ev    = push_only & full;
  assign unf_ev    = pop_only & empty;
  assign fault     = ovf_ev | unf_ev;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    stk_we  = 1'b0;
    pop_vld = 1'b0;
    pop_pc  = pc_q;

    if (push_only) begin
      if (!full) begin
        stk_we = 1'b1;
        ptr_d  = ptr_inc;
        cnt_d  = cnt_q + CNT_W'(1);
      end else if (WRAP_EN && !TRAP_EN) begin
        stk_we = 1'b1;
        ptr_d  = ptr_inc;
      end
    end else if (pop_only) begin
      pop_vld = 1'b1;
      if (!empty) begin
        ptr_d  = ptr_dec;
        cnt_d  = cnt_q - CNT_W'(1);
        pop_pc = stk_q[ptr_dec];
      end else if (TRAP_EN) begin
        pop_pc = TRAP_PC;
      end else if (WRAP_EN) begin
        ptr_d  = ptr_dec;
        pop_pc = stk_q[ptr_dec];
      end else begin
        pop_pc = RST_PC;
      end
    end
  end

  // A fault raised in the same cycle as FLAG_CLR keeps the flag set.
  always_comb begin
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    trap_d = TRAP_EN & fault;
    if (ovf_ev)            ovf_d = 1'b1;
    else if (bus.FLAG_CLR) ovf_d = 1'b0;
    if (unf_ev)            unf_d = 1'b1;
    else if (bus.FLAG_CLR) unf_d = 1'b0;
  end

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (bus.JMP)                pc_d = {bus.PCLATH[PC_W-9:JA_W-8], bus.JADDR};
    else if (bus.PCL_WE)        pc_d = {bus.PCLATH, bus.PCL_D};
    else if (TRAP_EN && fault)  pc_d = TRAP_PC;
    else if (pop_vld)           pc_d = pop_pc;
    else if (bus.HOLD)          pc_d = pc_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= RST_PC;
      ptr_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      trap_q <= trap_d;
    end
  end

  // Stack RAM is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (stk_we && !RST) stk_q[ptr_q] <= pc_q;
  end

  assign bus.PC      = pc_q;
  assign bus.TOS     = empty ? RST_PC : stk_q[ptr_dec];
  assign bus.STK_CNT = cnt_q;
  assign bus.OVF     = ovf_q;
  assign bus.UNF     = unf_q;
  assign bus.TRAP    = trap_q;
endmodule

// File: tb/tb_pic_pc_stack.sv
// Directed bench for pic_pc_stack: one circular (WRAP_MODE=1) and one saturating (WRAP_MODE=0) instance.
module tb_pic_pc_stack;
`ifdef STK_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic CLK;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  pic_pc_stack_if #(.PC_W(13), .JA_W(11), .STK_DEPTH(8)) bus_w ();
  pic_pc_stack_if #(.PC_W(13), .JA_W(11), .STK_DEPTH(8)) bus_s ();

  pic_pc_stack #(.PC_W(13), .JA_W(11), .STK_DEPTH(8), .WRAP_MODE(1),
                 .RESET_VEC(0), .TRAP_VEC(4)) dut_w (.CLK(CLK), .RST(RST), .bus(bus_w));
  pic_pc_stack #(.PC_W(13), .JA_W(11), .STK_DEPTH(8), .WRAP_MODE(0),
                 .RESET_VEC(0), .TRAP_VEC(4)) dut_s (.CLK(CLK), .RST(RST), .bus(bus_s));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    bus_w.HOLD = 0; bus_w.JMP = 0; bus_w.PUSH = 0; bus_w.POP = 0;
    bus_w.PCL_WE = 0; bus_w.FLAG_CLR = 0; bus_w.JADDR = '0; bus_w.PCL_D = '0;
    bus_s.HOLD = 0; bus_s.JMP = 0; bus_s.PUSH = 0; bus_s.POP = 0;
    bus_s.PCL_WE = 0; bus_s.FLAG_CLR = 0; bus_s.JADDR = '0; bus_s.PCL_D = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    idle();
    bus_w.PCLATH = '0;
    bus_s.PCLATH = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_pc", bus_w.PC, 32'h0);
    chk("rst_cnt", bus_w.STK_CNT, 32'h0);
    chk("rst_tos", bus_w.TOS, 32'h0);
    chk("rst_ovf", bus_w.OVF, 32'h0);
    chk("rst_unf", bus_w.UNF, 32'h0);
    chk("rst_trap", bus_w.TRAP, 32'h0);
    chk("rst_pc_s", bus_s.PC, 32'h0);

    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("inc_pc", bus_w.PC, 32'(i));
    end
    bus_w.HOLD = 1; tick(); chk("hold1_pc", bus_w.PC, 32'h5);
    bus_w.HOLD = 1; tick(); chk("hold2_pc", bus_w.PC, 32'h5);
    tick(); chk("resume_pc", bus_w.PC, 32'h6);

    // CALL from 0x040 then RETURN
    bus_w.PCLATH = 5'h00; bus_w.PCL_WE = 1; bus_w.PCL_D = 8'h40; tick();
    chk("pcl_pc40", bus_w.PC, 32'h040);
    bus_w.PCLATH = 5'h18; bus_w.JMP = 1; bus_w.PUSH = 1; bus_w.JADDR = 11'h123; tick();
    chk("call_pc", bus_w.PC, 32'h1923);
    chk("call_tos", bus_w.TOS, 32'h040);
    chk("call_cnt", bus_w.STK_CNT, 32'h1);
    bus_w.POP = 1; tick();
    chk("ret_pc", bus_w.PC, 32'h040);
    chk("ret_cnt", bus_w.STK_CNT, 32'h0);
    chk("ret_tos", bus_w.TOS, 32'h0);

    bus_w.PCLATH = 5'h1F; bus_w.PCL_WE = 1; bus_w.PCL_D = 8'hAB; tick();
    chk("pcl_pc", bus_w.PC, 32'h1FAB);
    bus_w.PCL_WE = 1; bus_w.PCL_D = 8'hAB; bus_w.JMP = 1; bus_w.JADDR = 11'h000; tick();
    chk("jmp_over_pcl", bus_w.PC, 32'h1800);

    // Circular stack: 9 pushes from 0x10
    bus_w.PCLATH = 5'h00; bus_w.PCL_WE = 1; bus_w.PCL_D = 8'h10; tick();
    chk("w_pc10", bus_w.PC, 32'h10);
    for (int k = 0; k < 9; k++) begin
      bus_w.PUSH = 1; tick();
    end
    chk("w_ovf", bus_w.OVF, 32'h1);
    chk("w_cnt_full", bus_w.STK_CNT, 32'h8);
    chk("w_tos_full", bus_w.TOS, TRAP_ON ? 32'h17 : 32'h18);
    chk("w_pc_after_push", bus_w.PC, TRAP_ON ? 32'h4 : 32'h19);
    chk("w_trap_ovf", bus_w.TRAP, 32'(TRAP_ON));
    for (int k = 0; k < 8; k++) begin
      bus_w.POP = 1; tick();
      chk("w_pop_pc", bus_w.PC, (TRAP_ON ? 32'h17 : 32'h18) - 32'(k));
    end
    chk("w_trap_cleared", bus_w.TRAP, 32'h0);
    chk("w_cnt_empty", bus_w.STK_CNT, 32'h0);
    chk("w_unf_before", bus_w.UNF, 32'h0);
    bus_w.POP = 1; tick();
    chk("w_unf_pc", bus_w.PC, TRAP_ON ? 32'h4 : 32'h18);
    chk("w_unf", bus_w.UNF, 32'h1);
    chk("w_unf_cnt", bus_w.STK_CNT, 32'h0);
    chk("w_trap_unf", bus_w.TRAP, 32'(TRAP_ON));
    bus_w.FLAG_CLR = 1; tick();
    chk("w_clr_ovf", bus_w.OVF, 32'h0);
    chk("w_clr_unf", bus_w.UNF, 32'h0);

    // Saturating stack: 9 pushes from 0x10, oldest entry must survive
    bus_s.PCLATH = 5'h00; bus_s.PCL_WE = 1; bus_s.PCL_D = 8'h10; tick();
    chk("s_pc10", bus_s.PC, 32'h10);
    for (int k = 0; k < 9; k++) begin
      bus_s.PUSH = 1; tick();
    end
    chk("s_ovf", bus_s.OVF, 32'h1);
    chk("s_cnt_full", bus_s.STK_CNT, 32'h8);
    chk("s_tos_full", bus_s.TOS, 32'h17);
    chk("s_pc_after_push", bus_s.PC, TRAP_ON ? 32'h4 : 32'h19);
    for (int k = 0; k < 8; k++) begin
      bus_s.POP = 1; tick();
      chk("s_pop_pc", bus_s.PC, 32'h17 - 32'(k));
    end
    chk("s_cnt_empty", bus_s.STK_CNT, 32'h0);
    bus_s.POP = 1; tick();
    chk("s_unf_pc", bus_s.PC, TRAP_ON ? 32'h4 : 32'h0);
    chk("s_unf", bus_s.UNF, 32'h1);
    chk("s_unf_cnt", bus_s.STK_CNT, 32'h0);
    chk("s_trap_unf", bus_s.TRAP, 32'(TRAP_ON));
    tick();
    chk("s_trap_pulse", bus_s.TRAP, 32'h0);
    bus_s.FLAG_CLR = 1; tick();
    chk("s_clr_ovf", bus_s.OVF, 32'h0);
    chk("s_clr_unf", bus_s.UNF, 32'h0);
    bus_s.FLAG_CLR = 1; bus_s.POP = 1; tick();
    chk("s_set_wins_unf", bus_s.UNF, 32'h1);
    chk("s_set_wins_ovf", bus_s.OVF, 32'h0);

    // PUSH+POP together leaves the stack alone
    bus_s.PCL_WE = 1; bus_s.PCL_D = 8'h20; tick();
    bus_s.PUSH = 1; tick();
    bus_s.PUSH = 1; tick();
    chk("s_cnt2", bus_s.STK_CNT, 32'h2);
    chk("s_tos21", bus_s.TOS, 32'h21);
    bus_s.PUSH = 1; bus_s.POP = 1; tick();
    chk("pp_cnt", bus_s.STK_CNT, 32'h2);
    chk("pp_pc", bus_s.PC, 32'h23);
    chk("pp_tos", bus_s.TOS, 32'h21);

    // Reset with a push pending
    bus_w.PUSH = 1; tick();
    bus_w.PUSH = 1; tick();
    chk("w_cnt2", bus_w.STK_CNT, 32'h2);
    RST = 1'b1; bus_w.PUSH = 1; tick();
    RST = 1'b0;
    chk("midrst_cnt", bus_w.STK_CNT, 32'h0);
    chk("midrst_pc", bus_w.PC, 32'h0);
    chk("midrst_tos", bus_w.TOS, 32'h0);
    tick();
    chk("midrst_resume", bus_w.PC, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
